// File: rtl/line_draw_pkg.sv
// Shared types and widths for the line-draw scheduler.
package line_draw_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    // One more bit than X_W so a full-width span of 1024 pixels fits.
    localparam int PIX_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Larger of the two axis spans, with dy widened to the x width.
    function automatic logic [X_W-1:0] major_span(input logic [X_W-1:0] dx,
                                                  input logic [Y_W-1:0] dy);
        logic [X_W-1:0] dy_ext;
        dy_ext = X_W'(dy);
        return (dx >= dy_ext) ? dx : dy_ext;
    endfunction

endpackage

// File: rtl/line_draw_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant_q;
    logic last_grant_d;

    // Select a winner from the current requests and the round-robin pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_idx    = req[1];
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        if (req == 2'b11) begin
            grant_idx = ~last_grant_q;
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
        if (advance) begin
            last_grant_d = grant_idx;
        end
    end

    // Round-robin pointer; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/line_draw_scheduler.sv
// Shares one line-drawing datapath between two requesters: arbitrates, latches
// the winning line, strobes set, times the draw and returns a done pulse.
module line_draw_scheduler
    import line_draw_pkg::*;
#(
    parameter int CYCLES_PER_PIXEL = 3,
    parameter int SETUP_CYCLES     = 2,
    parameter int COLOR_W          = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    input  logic [1:0][X_W-1:0]         req_x0,
    input  logic [1:0][X_W-1:0]         req_x1,
    input  logic [1:0][Y_W-1:0]         req_y0,
    input  logic [1:0][Y_W-1:0]         req_y1,
    input  logic [1:0][COLOR_W-1:0]     req_color,
    output logic [1:0]                  req_ready,
    output logic [1:0]                  req_done,
    output logic [X_W-1:0]              x0,
    output logic [X_W-1:0]              x1,
    output logic [Y_W-1:0]              y0,
    output logic [Y_W-1:0]              y1,
    output logic                        set,
    output logic [COLOR_W-1:0]          color,
    output logic                        draw_en,
    output logic                        busy
);

    localparam int SET_W = (SETUP_CYCLES > 1)     ? $clog2(SETUP_CYCLES)     : 1;
    localparam int PH_W  = (CYCLES_PER_PIXEL > 1) ? $clog2(CYCLES_PER_PIXEL) : 1;

    state_t             state_q,     state_d;
    logic [X_W-1:0]     x0_q,        x0_d;
    logic [X_W-1:0]     x1_q,        x1_d;
    logic [Y_W-1:0]     y0_q,        y0_d;
    logic [Y_W-1:0]     y1_q,        y1_d;
    logic [COLOR_W-1:0] color_q,     color_d;
    logic               owner_q,     owner_d;
    logic [PIX_W-1:0]   pix_cnt_q,   pix_cnt_d;
    logic [PH_W-1:0]    phase_q,     phase_d;
    logic [SET_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic               in_setup_q,  in_setup_d;

    logic [1:0]     grant;
    logic           grant_idx;
    logic           handshake;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign dx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign dy = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);

    // Ready is offered only while idle and out of reset; the grant is a subset of valid.
    assign req_ready = (state_q == S_IDLE && !reset) ? grant : 2'b00;
    assign handshake = |(req_ready & req_valid);

    assign set      = (state_q == S_ISSUE);
    assign draw_en  = (state_q == S_WAIT) && !in_setup_q;
    assign req_done = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy     = (state_q != S_IDLE);
    assign x0       = x0_q;
    assign x1       = x1_q;
    assign y0       = y0_q;
    assign y1       = y1_q;
    assign color    = color_q;

    // Next-state logic: latch on handshake, size the line, then time setup and pixels.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        color_d     = color_q;
        owner_d     = owner_q;
        pix_cnt_d   = pix_cnt_q;
        phase_d     = phase_q;
        setup_cnt_d = setup_cnt_q;
        in_setup_d  = in_setup_q;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    x0_d    = req_x0[grant_idx];
                    x1_d    = req_x1[grant_idx];
                    y0_d    = req_y0[grant_idx];
                    y1_d    = req_y1[grant_idx];
                    color_d = req_color[grant_idx];
                    owner_d = grant_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pix_cnt_d = PIX_W'(major_span(dx, dy)) + PIX_W'(1);
                phase_d   = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                setup_cnt_d = SET_W'(SETUP_CYCLES - 1);
                in_setup_d  = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (in_setup_q) begin
                    if (setup_cnt_q == '0) begin
                        in_setup_d = 1'b0;
                    end else begin
                        setup_cnt_d = setup_cnt_q - SET_W'(1);
                    end
                end else if (phase_q == PH_W'(CYCLES_PER_PIXEL - 1)) begin
                    // Last phase of a pixel: either move to the next pixel or finish.
                    phase_d = '0;
                    if (pix_cnt_q == PIX_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        pix_cnt_d = pix_cnt_q - PIX_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and drops any in-flight line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            owner_q     <= 1'b0;
            pix_cnt_q   <= '0;
            phase_q     <= '0;
            setup_cnt_q <= '0;
            in_setup_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            owner_q     <= owner_d;
            pix_cnt_q   <= pix_cnt_d;
            phase_q     <= phase_d;
            setup_cnt_q <= setup_cnt_d;
            in_setup_q  <= in_setup_d;
        end
    end

endmodule
